i2s_slave_tx: RTL and testbench
===============================

// Module: i2s_slave_tx
// PURPOSE
//  I2S slave transmitter: follows an externally generated lrclk (master elsewhere) and serialises
//  buffered stereo frames onto sdata, MSB first, with the standard one-bit delay after each lrclk edge.
//  Sits between a sample producer (valid/ready) and an I2S link whose master owns sclk/lrclk.
//  Complements the master-mode transmitter and slave-mode receiver already in the I2S directory.
// PARAMETERS
//  DATA_W      32  bits per channel word; slot may be longer (pad 0) or shorter (LSBs dropped)
//  FIFO_DEPTH  4   stereo frames buffered; power of two, >=2
// PORTS
//  sclk        in   1         bit clock; sole clock, all logic on posedge
//  rst         in   1         asynchronous, active-low reset
//  lrclk       in   1         word select from master; 0 = left slot, 1 = right slot
//  s_valid     in   1         producer frame valid
//  s_left      in   DATA_W    left sample
//  s_right     in   DATA_W    right sample
//  s_ready     out  1         = !fifo_full; push occurs when s_valid & s_ready at posedge
//  sdata       out  1         serial data, registered
//  underflow   out  1         1-cycle pulse: left slot started with FIFO empty
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered
// BEHAVIOUR
//  Reset (rst=0): sdata=0, underflow=0, fifo_level=0, s_ready=1, FIFO pointers/shifter cleared,
//   lr_d=0, FSM=IDLE. Reset mid-frame aborts the frame; no partial data retained.
//  lrclk sampled into lr_d each posedge; fall = lr_d & ~lrclk, rise = ~lr_d & lrclk.
//  FSM: IDLE -> LEFT on fall (rises ignored in IDLE); LEFT -> RIGHT on rise; RIGHT -> LEFT on fall.
//   IDLE: sdata=0. First frame goes out only after first observed falling lrclk edge.
//  On fall (from IDLE or RIGHT): pop one frame if FIFO non-empty; shifter <= left, hold <= right,
//   sdata <= left[DATA_W-1] in the same posedge (=> MSB visible one sclk after master's edge).
//   If FIFO empty: shifter,hold <= 0, sdata <= 0, underflow=1 for that cycle; frame is zeros.
//  On rise (LEFT->RIGHT): shifter <= hold, sdata <= hold[DATA_W-1].
//  Other cycles in LEFT/RIGHT: sdata <= next bit (shift left, fill 0); after DATA_W bits sdata=0
//   until next edge. Edge arriving before DATA_W bits sent truncates: new word starts immediately.
//  Push and pop in same cycle: both performed, level unchanged. Push when full impossible
//   (s_ready=0). Pop and push same cycle with FIFO empty: pop sees empty -> underflow; pushed
//   frame stays buffered (no bypass).
//  s_ready combinational from full flag; level updated on posedge after push/pop.
//  Latency: a frame pushed before a left-slot fall edge transmits starting that edge.
// STRUCTURE
//  Shared i2s_pkg: CHAN_LEFT/CHAN_RIGHT lrclk polarity constants, default DATA_W, FSM state
//   encodings (ST_IDLE, ST_LEFT, ST_RIGHT).
//  One sub-module: i2s_frame_fifo (sync FIFO, 2*DATA_W wide, FIFO_DEPTH deep, full/empty/level).
//  Top holds lrclk edge detect, FSM, shifter, hold register, underflow pulse.
// TESTING (bench models an I2S master: 64 sclk per frame, 32-bit slots; checks via existing slave rx)
//  1 Push L=32'hA5A5_0001,R=32'h5A5A_0002 before first fall -> rx returns same pair; MSB one sclk after edge.
//  2 No pushes, run 3 frames -> sdata=0 throughout, underflow pulses 3 times, one per left-slot fall.
//  3 Push 5 frames back-to-back with DATA_W=32, FIFO_DEPTH=4 -> s_ready low after 4th, 5th accepted
//    after first pop; all 5 frames emerge in order, fifo_level peaks at 4.
//  4 Release reset while lrclk=1 mid-right-slot -> sdata=0, no underflow until first fall; first
//    rise ignored.
//  5 Assert rst mid-left-slot with 2 frames buffered -> sdata=0 immediately, fifo_level=0,
//    s_ready=1; after release next fall gives underflow.
//  6 Master with 24-sclk slots, DATA_W=32, L=32'hFFFF_FF00 -> rx sees 24 MSBs, right word starts on rise.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions.
//   CHAN_LEFT / CHAN_RIGHT : lrclk level that selects each channel slot
//   DEFAULT_DATA_W         : default bits per channel word
//   i2s_state_e            : slot-tracking FSM states for the transmitters
package i2s_pkg;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous FIFO holding complete stereo frames.
// The read word is always the oldest entry (show-ahead), so the consumer can
// load it in the same clock edge that it pops.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears pointers only)
//   push     in   write request; ignored while full
//   wr_data  in   WIDTH-bit frame to write
//   pop      in   read request; ignored while empty
//   rd_data  out  oldest buffered frame (undefined content when empty)
//   full     out  DEPTH frames buffered
//   empty    out  no frames buffered
//   level    out  frames currently buffered
module i2s_frame_fifo import i2s_pkg::*; #(
  parameter int WIDTH = 2 * DEFAULT_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push_ok;
  logic        pop_ok;

  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter. Follows the master's lrclk and serialises buffered
// stereo frames onto sdata, MSB first, one sclk after each lrclk edge.
//   sclk        in   bit clock, all logic on posedge
//   rst         in   asynchronous active-low reset
//   lrclk       in   word select (0 = left slot, 1 = right slot)
//   s_valid     in   producer frame valid
//   s_left      in   left sample
//   s_right     in   right sample
//   s_ready     out  frame buffer not full
//   sdata       out  registered serial data
//   underflow   out  one-cycle pulse when a left slot starts with no frame
//   fifo_level  out  frames currently buffered
module i2s_slave_tx import i2s_pkg::*; #(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sclk,
  input  logic                          rst,
  input  logic                          lrclk,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  output logic                          s_ready,
  output logic                          sdata,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic                  lr_d_reg;
  logic                  fall;
  logic                  rise;
  i2s_state_e            state_reg, state_next;
  logic [DATA_W-1:0]     shifter_reg, shifter_next;
  logic [DATA_W-1:0]     hold_reg, hold_next;
  logic                  sdata_reg, sdata_next;
  logic                  underflow_reg, underflow_next;
  logic                  load_left;
  logic                  load_right;
  logic                  pop;

  logic [2*DATA_W-1:0]   fifo_rd_data;
  logic [DATA_W-1:0]     fifo_left;
  logic [DATA_W-1:0]     fifo_right;
  logic                  fifo_full;
  logic                  fifo_empty;

  i2s_frame_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (rst),
    .push    (s_valid),
    .wr_data ({s_left, s_right}),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign fifo_left  = fifo_rd_data[2*DATA_W-1:DATA_W];
  assign fifo_right = fifo_rd_data[DATA_W-1:0];

  assign s_ready   = ~fifo_full;
  assign sdata     = sdata_reg;
  assign underflow = underflow_reg;

  assign fall = (lr_d_reg == CHAN_RIGHT) && (lrclk == CHAN_LEFT);
  assign rise = (lr_d_reg == CHAN_LEFT)  && (lrclk == CHAN_RIGHT);

  always_comb begin
    state_next     = state_reg;
    // Default: keep shifting out; zero fill makes bits past DATA_W read as 0,
    // which pads slots longer than the word without a bit counter.
    shifter_next   = {shifter_reg[DATA_W-2:0], 1'b0};
    hold_next      = hold_reg;
    sdata_next     = shifter_reg[DATA_W-2];
    underflow_next = 1'b0;
    load_left      = 1'b0;
    load_right     = 1'b0;
    pop            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Stay silent until the first left slot is seen; rises are ignored.
        sdata_next   = 1'b0;
        shifter_next = shifter_reg;
        load_left    = fall;
      end
      ST_LEFT:  load_right = rise;
      ST_RIGHT: load_left  = fall;
      default:  state_next = ST_IDLE;
    endcase

    // An edge always restarts the word, truncating any unsent bits.
    if (load_left) begin
      state_next = ST_LEFT;
      if (!fifo_empty) begin
        pop          = 1'b1;
        shifter_next = fifo_left;
        hold_next    = fifo_right;
        sdata_next   = fifo_left[DATA_W-1];
      end else begin
        shifter_next   = '0;
        hold_next      = '0;
        sdata_next     = 1'b0;
        underflow_next = 1'b1;
      end
    end

    if (load_right) begin
      state_next   = ST_RIGHT;
      shifter_next = hold_reg;
      sdata_next   = hold_reg[DATA_W-1];
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      lr_d_reg      <= 1'b0;
      state_reg     <= ST_IDLE;
      shifter_reg   <= '0;
      hold_reg      <= '0;
      sdata_reg     <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      lr_d_reg      <= lrclk;
      state_reg     <= state_next;
      shifter_reg   <= shifter_next;
      hold_reg      <= hold_next;
      sdata_reg     <= sdata_next;
      underflow_reg <= underflow_next;
    end
  end

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: models an I2S master driving lrclk, a producer
// pushing frames, and a receiver that reassembles each slot and compares it
// with the frame the protocol says must be on the wire.
module tb_i2s_slave_tx;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  localparam int M_IDLE  = 0;
  localparam int M_LEFT  = 1;
  localparam int M_RIGHT = 2;

  logic          sclk;
  logic          rst;
  logic          lrclk;
  logic          s_valid;
  logic [W-1:0]  s_left;
  logic [W-1:0]  s_right;
  logic          s_ready;
  logic          sdata;
  logic          underflow;
  logic [2:0]    fifo_level;

  i2s_slave_tx #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .s_valid    (s_valid),
    .s_left     (s_left),
    .s_right    (s_right),
    .s_ready    (s_ready),
    .sdata      (sdata),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    longint       tag;   // posedge index at which the push happens
  } frame_t;

  frame_t  exp_q[$];
  longint  cyc = 0;
  int      n_checks = 0;
  int      n_pass = 0;
  int      uf_count = 0;
  int      peak_level = 0;
  int      frame_no = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // First n bits a receiver sees for a slot of n sclks: MSB-first word,
  // truncated when short, zero padded when long.
  function automatic logic [63:0] exp_bits(input logic [W-1:0] w, input int n);
    logic [63:0] full;
    full = {w, 32'h0};
    if (n <= 0) return 64'h0;
    return full >> (64 - n);
  endfunction

  // ---------------- monitor / reference receiver ----------------
  int            mstate = M_IDLE;
  logic          prev_lr = 1'b0;
  logic [63:0]   act_bits = '0;
  int            bit_cnt = 0;
  logic [W-1:0]  cur_l = '0;
  logic [W-1:0]  cur_r = '0;
  logic          exp_uf;
  logic          m_fall;
  logic          m_rise;
  frame_t        fr;

  task automatic close_slot(input bit is_right);
    if (is_right) begin
      chk("right_slot", act_bits, exp_bits(cur_r, bit_cnt));
      $display("frame %0d: L=%08h R=%08h slot=%0d sclk", frame_no, cur_l, cur_r, bit_cnt);
      frame_no++;
    end else begin
      chk("left_slot", act_bits, exp_bits(cur_l, bit_cnt));
    end
  endtask

  always @(posedge sclk) begin
    #1;
    if (!rst) begin
      chk("rst_sdata", sdata, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", s_ready, 1);
      exp_q.delete();
      mstate   = M_IDLE;
      prev_lr  = 1'b0;
      bit_cnt  = 0;
      act_bits = '0;
    end else begin
      m_fall = prev_lr && !lrclk;
      m_rise = !prev_lr && lrclk;
      exp_uf = 1'b0;
      if (m_fall && mstate != M_LEFT) begin
        if (mstate == M_RIGHT) close_slot(1'b1);
        // Only frames pushed at an earlier posedge are visible to the pop.
        if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
          fr    = exp_q.pop_front();
          cur_l = fr.l;
          cur_r = fr.r;
        end else begin
          cur_l  = '0;
          cur_r  = '0;
          exp_uf = 1'b1;
        end
        mstate   = M_LEFT;
        bit_cnt  = 0;
        act_bits = '0;
      end else if (m_rise && mstate == M_LEFT) begin
        close_slot(1'b0);
        mstate   = M_RIGHT;
        bit_cnt  = 0;
        act_bits = '0;
      end

      if (mstate == M_IDLE) begin
        chk("idle_sdata", sdata, 0);
      end else begin
        act_bits = {act_bits[62:0], sdata};
        if (bit_cnt < 64) bit_cnt++;
      end

      chk("underflow", underflow, exp_uf);
      chk("fifo_level", fifo_level, exp_q.size());
      chk("s_ready", s_ready, (exp_q.size() < DEPTH) ? 1 : 0);
      if (underflow) uf_count++;
      if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
      prev_lr = lrclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_master(input int nframes, input int slot, input int pre);
    repeat (pre) begin
      @(negedge sclk);
      lrclk = 1'b1;
    end
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 2 * slot; i++) begin
        @(negedge sclk);
        lrclk = (i >= slot);
      end
    end
  endtask

  task automatic produce(input int n, input bit rnd, input logic [W-1:0] lv,
                         input logic [W-1:0] rv, input int max_gap);
    int  waited;
    int  gap;
    bit  acc;
    for (int k = 0; k < n; k++) begin
      @(negedge sclk);
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(negedge sclk);
      end
      s_left  = rnd ? W'($urandom) : lv;
      s_right = rnd ? W'($urandom) : rv;
      s_valid = 1'b1;
      waited  = 0;
      acc     = 1'b0;
      while (!acc) begin
        if (s_ready) begin
          acc = 1'b1;
          exp_q.push_back('{l: s_left, r: s_right, tag: cyc + 1});
        end else if (waited > 600) begin
          chk("push_wait_timeout", 0, 1);
          s_valid = 1'b0;
          return;
        end else begin
          waited++;
          @(negedge sclk);
        end
      end
    end
    @(negedge sclk);
    s_valid = 1'b0;
  endtask

  initial begin
    int uf0;
    int slots[4];
    slots = '{32, 24, 40, 33};

    rst     = 1'b0;
    lrclk   = 1'b1;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (3) @(negedge sclk);
    rst = 1'b1;

    // Single known frame ahead of the first left slot.
    produce(1, 1'b0, 32'hA5A5_0001, 32'h5A5A_0002, 0);
    run_master(2, 32, 2);

    // Empty buffer: three underflows, all-zero slots.
    uf0 = uf_count;
    run_master(3, 32, 0);
    chk("underflow_pulses", uf_count - uf0, 3);

    // Back-to-back pushes into a full buffer.
    peak_level = 0;
    fork
      run_master(5, 32, 12);
      produce(5, 1'b1, '0, '0, 0);
    join
    chk("peak_level", peak_level, DEPTH);

    // Reset released mid right slot; leading rise must be ignored.
    @(negedge sclk);
    rst   = 1'b0;
    lrclk = 1'b1;
    repeat (3) @(negedge sclk);
    rst = 1'b1;
    uf0 = uf_count;
    run_master(1, 32, 5);
    chk("uf_after_release", uf_count - uf0, 1);

    // Reset mid left slot with two frames still buffered.
    produce(3, 1'b1, '0, '0, 0);
    @(negedge sclk);
    lrclk = 1'b0;
    repeat (10) @(negedge sclk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_sdata", sdata, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_ready", s_ready, 1);
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    uf0 = uf_count;
    run_master(1, 32, 3);
    chk("uf_after_abort", uf_count - uf0, 1);

    // Short 24-sclk slots truncate each word.
    produce(2, 1'b0, 32'hFFFF_FF00, 32'h00AB_CDEF, 0);
    run_master(3, 24, 0);

    // Random traffic over several slot lengths.
    for (int s = 0; s < 4; s++) begin
      fork
        run_master(6, slots[s], 0);
        produce(6, 1'b1, '0, '0, 40);
      join
    end

    repeat (4) @(negedge sclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
